sr_latch_bank: RTL and testbench
================================

# sr_latch_bank

Clocked, parametrised successor to the gate-level NAND SR latch: WIDTH independent set/reset storage channels sharing one clock. Each channel keeps the active-low set/reset input convention. The forbidden both-asserted condition resolves deterministically per a MODE parameter instead of producing an undefined state. Conflicts are flagged per channel, and a saturating counter records the number of cycles in which q changed. Intended as the storage/status primitive for control flags in later chapters.

## Interface
- WIDTH, 8: number of channels, 1..32.
- MODE, 0: both-asserted resolution.
  - 0 = reset-dominant.
  - 1 = set-dominant.
  - 2 = hold.
  - 3 = toggle.
- INIT, {WIDTH{1'b0}}: q value loaded on reset.
- CNT_W, 8: change-counter width, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- sbar  input  WIDTH  per-channel set, active-low.
- rbar  input  WIDTH  per-channel reset, active-low.
- clr_conflict  input  1  clears all conflict flags (active-high, one-cycle pulse).
- clr_cnt  input  1  clears change counter (active-high).
- q  output  WIDTH  stored state.
- qbar  output  WIDTH  always exactly ~q, including during reset.
- conflict  output  WIDTH  sticky per-channel "both asserted" flag.
- change_cnt  output  CNT_W  saturating count of cycles where q changed.

## Operation
Per channel i, decode s = ~sbar[i] and r = ~rbar[i], then compute next state:
- s=0, r=0: hold.
- s=1, r=0: q←1.
- s=0, r=1: q←0.
- s=1, r=1: resolve by MODE.
  - MODE 0: q←0.
  - MODE 1: q←1.
  - MODE 2: hold.
  - MODE 3: q←~q.

Conflict flags:
- conflict[i] sets on any cycle with s=r=1 for channel i, in every MODE.
- Flags stay set until clr_conflict.
- clr_conflict and a new conflict in the same cycle: the flag ends 1 (set wins over clear).

Change counter:
- Increments by 1 on any cycle where the next q differs from the current q in at least one bit, regardless of how many bits differ.
- Saturates at 2^CNT_W−1; never wraps.
- clr_cnt takes priority over an increment in the same cycle; the counter goes to 0.

Reset:
- rst dominates all other inputs.
- On reset: q=INIT, qbar=~INIT, conflict=0, change_cnt=0.
- Reset asserted mid-sequence discards that cycle's set/reset/clear inputs.
- The load of INIT itself does not count as a change.
- The first post-reset edge with rst=0 evaluates inputs normally.

All channels are independent. Simultaneous activity on multiple channels is processed in the same cycle.

## Timing
- Inputs are sampled on the rising clk edge. q, qbar, conflict and change_cnt update at that edge: one-cycle latency, registered outputs, no combinational input-to-output path.
- No handshake. Every edge is an evaluation, and sbar/rbar are level-sensitive.
  - A held set keeps q=1 with no further counts.
  - A held s=r=1 in MODE 3 toggles every cycle and counts every cycle.
- sbar/rbar must be synchronous to clk. Asynchronous sources need external synchronisation.

## Structure
- Package sr_bank_pkg:
  - mode localparams MODE_RST_DOM=0, MODE_SET_DOM=1, MODE_HOLD=2, MODE_TOGGLE=3;
  - a function computing one channel's next state from (q, s, r, mode).
- Sub-module sr_cell: one channel. It holds the q flop and the conflict flop, with inputs clk, rst, init bit, sbar, rbar, clr_conflict. It outputs q, conflict and a next-differs bit.
- The top generates WIDTH sr_cell instances, ORs the next-differs bits, and owns the counter.
- Elaboration check: MODE >3, WIDTH outside 1..32, or CNT_W <2 is a fatal error.

## Test plan
- Reset, WIDTH=8, INIT=8'hA5, all inputs high → q=A5, qbar=5A, conflict=00, change_cnt=0. Hold 10 cycles → unchanged, count 0.
- MODE 0: sbar=8'hFE for 1 cycle, then rbar=8'hFE for 1 cycle, starting from q=A5 → q=A5 (bit0 already 1, no count), then q=A4, change_cnt=1.
- Each MODE 0..3, channel 0 with sbar[0]=rbar[0]=0 for 3 cycles from q[0]=0:
  - MODE 0 → q[0]=0, count unchanged.
  - MODE 1 → q[0]=1 after edge 1, count+1.
  - MODE 2 → q[0]=0 held, count unchanged.
  - MODE 3 → q[0] = 1, 0, 1, count+3.
  - conflict[0]=1 in all four modes.
- clr_conflict pulsed alongside a new conflict on channel 3 while channel 0's flag is set → conflict[0]→0, conflict[3]=1.
- CNT_W=2, MODE 3, persistent conflict for 6 cycles → count 1, 2, 3, 3, 3, 3. clr_cnt with a change in the same cycle → 0.
- rst asserted in the same cycle as sbar=00 → q=INIT, count 0, conflict 0. Set applied the next cycle takes effect one edge later.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the clocked SR latch bank: resolution modes and
// the single-channel next-state rule.
package sr_bank_pkg;

    localparam int MODE_RST_DOM = 0;
    localparam int MODE_SET_DOM = 1;
    localparam int MODE_HOLD    = 2;
    localparam int MODE_TOGGLE  = 3;

    // s and r are already decoded to active-high here.
    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input int mode);
        logic nq;
        nq = q;
        unique case ({s, r})
            2'b00: nq = q;
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_RST_DOM: nq = 1'b0;
                    MODE_SET_DOM: nq = 1'b1;
                    MODE_HOLD:    nq = q;
                    default:      nq = ~q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_bank_cell.sv
// One storage channel: the q flop, its sticky conflict flag, and a flag
// telling the top whether q is about to change.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter int MODE = MODE_RST_DOM
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic sbar,
    input  logic rbar,
    input  logic clr_conflict,
    output logic q,
    output logic conflict,
    output logic differs
);

    logic s;
    logic r;
    logic q_nxt;

    assign s       = ~sbar;
    assign r       = ~rbar;
    assign q_nxt   = sr_next(q, s, r, MODE);
    assign differs = (q_nxt != q);

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= init;
            conflict <= 1'b0;
        end else begin
            q <= q_nxt;
            // a fresh conflict outranks a clear in the same cycle
            if (s && r)
                conflict <= 1'b1;
            else if (clr_conflict)
                conflict <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_latch_bank.sv
// WIDTH independent clocked SR channels with deterministic conflict
// resolution, sticky conflict flags and a saturating change counter.
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               MODE  = MODE_RST_DOM,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sbar,
    input  logic [WIDTH-1:0] rbar,
    input  logic             clr_conflict,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] change_cnt
);

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $fatal(1, "sr_latch_bank: MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "sr_latch_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 2) begin : g_bad_cntw
        $fatal(1, "sr_latch_bank: CNT_W must be at least 2");
    end

    logic [WIDTH-1:0] differs;
    logic             any_change;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(.MODE(MODE)) u_cell (
            .clk          (clk),
            .rst          (rst),
            .init         (INIT[i]),
            .sbar         (sbar[i]),
            .rbar         (rbar[i]),
            .clr_conflict (clr_conflict),
            .q            (q[i]),
            .conflict     (conflict[i]),
            .differs      (differs[i])
        );
    end

    // qbar is derived, never stored, so it tracks q even through reset
    assign qbar       = ~q;
    assign any_change = |differs;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt)
            change_cnt <= '0;
        else if (any_change && (change_cnt != {CNT_W{1'b1}}))
            change_cnt <= change_cnt + 1'b1;
    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Drives five banks (MODE 0..3 with an 8-bit counter, MODE 3 with a 2-bit
// counter) from shared inputs and compares each against a reference model.
module tb_sr_latch_bank;

    localparam logic [7:0] INIT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sbar;
    logic [7:0] rbar;
    logic       clr_conflict;
    logic       clr_cnt;

    logic [7:0] q_d    [5];
    logic [7:0] qbar_d [5];
    logic [7:0] conf_d [5];
    logic [7:0] cnt_d  [4];
    logic [1:0] cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [7:0]  m_q    [5];
    logic [7:0]  m_conf [5];
    int unsigned m_cnt  [5];
    int          m_mode [5] = '{0, 1, 2, 3, 3};
    int unsigned m_max  [5] = '{255, 255, 255, 255, 3};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_latch_bank #(.WIDTH(8), .MODE(g), .INIT(INIT), .CNT_W(8)) u_dut (
            .clk(clk), .rst(rst), .sbar(sbar), .rbar(rbar),
            .clr_conflict(clr_conflict), .clr_cnt(clr_cnt),
            .q(q_d[g]), .qbar(qbar_d[g]), .conflict(conf_d[g]), .change_cnt(cnt_d[g])
        );
    end

    sr_latch_bank #(.WIDTH(8), .MODE(3), .INIT(INIT), .CNT_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .sbar(sbar), .rbar(rbar),
        .clr_conflict(clr_conflict), .clr_cnt(clr_cnt),
        .q(q_d[4]), .qbar(qbar_d[4]), .conflict(conf_d[4]), .change_cnt(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the latch truth table to whatever inputs are present at the edge.
    task automatic model_edge();
        for (int m = 0; m < 5; m++) begin
            logic [7:0] nq;
            logic [7:0] both;
            if (rst) begin
                m_q[m]    = INIT;
                m_conf[m] = 8'h00;
                m_cnt[m]  = 0;
            end else begin
                nq   = m_q[m];
                both = 8'h00;
                for (int b = 0; b < 8; b++) begin
                    logic s, r;
                    s = !sbar[b];
                    r = !rbar[b];
                    if (s && r) begin
                        both[b] = 1'b1;
                        if (m_mode[m] == 0)      nq[b] = 1'b0;
                        else if (m_mode[m] == 1) nq[b] = 1'b1;
                        else if (m_mode[m] == 3) nq[b] = !m_q[m][b];
                    end else if (s) begin
                        nq[b] = 1'b1;
                    end else if (r) begin
                        nq[b] = 1'b0;
                    end
                end
                m_conf[m] = (clr_conflict ? 8'h00 : m_conf[m]) | both;
                if (clr_cnt)
                    m_cnt[m] = 0;
                else if (nq != m_q[m] && m_cnt[m] < m_max[m])
                    m_cnt[m] = m_cnt[m] + 1;
                m_q[m] = nq;
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 5; m++) begin
            logic [31:0] cnt;
            cnt = (m == 4) ? {30'b0, cnt4} : {24'b0, cnt_d[m]};
            chk($sformatf("q_m%0d", m),        {24'b0, q_d[m]},    {24'b0, m_q[m]});
            chk($sformatf("qbar_m%0d", m),     {24'b0, qbar_d[m]}, {24'b0, ~m_q[m]});
            chk($sformatf("conflict_m%0d", m), {24'b0, conf_d[m]}, {24'b0, m_conf[m]});
            chk($sformatf("cnt_m%0d", m),      cnt,                m_cnt[m]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 1'b0; sbar = 8'hFF; rbar = 8'hFF; clr_conflict = 1'b0; clr_cnt = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 5; m++) begin
            m_q[m] = INIT; m_conf[m] = 8'h00; m_cnt[m] = 0;
        end
        idle();
        rst = 1'b1;
        #2;
        step();
        step();
        chk("reset_q_const",    {24'b0, q_d[0]},    32'hA5);
        chk("reset_qbar_const", {24'b0, qbar_d[0]}, 32'h5A);
        chk("reset_cnt_const",  {24'b0, cnt_d[0]},  32'h0);
        idle();
        repeat (10) step();
        chk("hold_cnt_const", {24'b0, cnt_d[0]}, 32'h0);

        // set bit0 (already 1), then reset it
        sbar = 8'hFE; step();
        chk("set_noop_cnt", {24'b0, cnt_d[0]}, 32'h0);
        sbar = 8'hFF; rbar = 8'hFE; step();
        chk("reset_bit0_q",   {24'b0, q_d[0]},   32'hA4);
        chk("reset_bit0_cnt", {24'b0, cnt_d[0]}, 32'h1);
        idle();

        // conflict on channel 0 for 3 cycles from q[0]=0
        sbar = 8'hFE; rbar = 8'hFE;
        repeat (3) step();
        chk("toggle3_q0", {31'b0, q_d[3][0]}, 32'h1);
        chk("toggle3_cnt", {24'b0, cnt_d[3]}, 32'h4);
        idle(); step();

        // clear alongside a new conflict on channel 3
        sbar = 8'hF7; rbar = 8'hF7; clr_conflict = 1'b1; step();
        chk("clr_conf_m2", {24'b0, conf_d[2]}, 32'h08);
        idle(); step();

        // persistent conflict everywhere: 2-bit counter saturates
        clr_cnt = 1'b1; step();
        clr_cnt = 1'b0; sbar = 8'h00; rbar = 8'h00;
        repeat (6) step();
        chk("sat_cnt4", {30'b0, cnt4}, 32'h3);
        clr_cnt = 1'b1; step();
        chk("clr_with_change_cnt4", {30'b0, cnt4}, 32'h0);

        // reset wins over a same-cycle set
        clr_cnt = 1'b0; rbar = 8'hFF; sbar = 8'h00; rst = 1'b1; step();
        chk("rst_over_set_q", {24'b0, q_d[1]}, 32'hA5);
        rst = 1'b0; step();
        chk("set_after_rst_q", {24'b0, q_d[1]}, 32'hFF);
        idle();

        // randomized traffic, active-low inputs biased towards idle
        for (int k = 0; k < 400; k++) begin
            sbar         = 8'($urandom | $urandom);
            rbar         = 8'($urandom | $urandom);
            clr_conflict = ($urandom_range(0, 7) == 0);
            clr_cnt      = ($urandom_range(0, 31) == 0);
            rst          = ($urandom_range(0, 63) == 0);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
